multicycle_controller: RTL and testbench

//  Main control FSM for the multicycle RV32I datapath. Decodes Op/F3/F7, sequences fetch/decode/execute/

---
 rtl/riscv_ctrl_pkg.sv | 98 +++++++++
 rtl/alu_op_decoder.sv | 64 ++++++
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared encodings for the multicycle RV32I control path:
//                FSM state enum, opcode constants, datapath select codes.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Controller states; ILLEGAL is a terminal trap left only through reset.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_LINK     = 4'd10,
        S_JUMP     = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    // Major opcodes (Inst[6:0])
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // funct3 values that qualify the memory and jalr classes
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    // ALU operation
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    // Immediate format
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU source A (11 = constant zero, never selected by this controller)
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // ALU source B
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    // Result bus source
    localparam logic [1:0] RES_ALUOUTREG = 2'b00;
    localparam logic [1:0] RES_MDR       = 2'b01;
    localparam logic [1:0] RES_ALUOUT    = 2'b10;

    // Register-file write data source
    localparam logic [1:0] RDS_RESULT    = 2'b00;
    localparam logic [1:0] RDS_ALUOUTREG = 2'b01;
    localparam logic [1:0] RDS_IMM       = 2'b10;
    localparam logic [1:0] RDS_SIGNBIT   = 2'b11;

    // Only beq/bne/blt/bge are implemented; everything else traps.
    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Branch decision from the subtract flags; blt/bge use the raw sign bit.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                          input logic sign_bit);
        logic taken;
        case (f3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = sign_bit;
            3'b101:  taken = !sign_bit;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decoder
//  Description : Maps (R/I class, funct3, funct7) to an ALU operation, flags
//                slt/slti, and reports whether the combination is supported.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       is_r,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    output logic [2:0] alu_op,
    output logic       is_slt,
    output logic       legal
);

    logic f7_ok;

    // R-type needs funct7 all zero except for sub; I-type ignores funct7.
    assign f7_ok = !is_r || (f7 == 7'b0000000);

    // Operation / legality table
    always_comb begin
        alu_op = ALU_ADD;
        is_slt = 1'b0;
        legal  = 1'b0;
        case (f3)
            3'b000: begin
                if (is_r && (f7 == 7'b0100000)) begin
                    alu_op = ALU_SUB;
                    legal  = 1'b1;
                end else begin
                    alu_op = ALU_ADD;
                    legal  = f7_ok;
                end
            end
            3'b111: begin
                alu_op = ALU_AND;
                legal  = f7_ok;
            end
            3'b110: begin
                alu_op = ALU_OR;
                legal  = f7_ok;
            end
            3'b100: begin
                alu_op = ALU_XOR;
                legal  = f7_ok;
            end
            3'b010: begin
                alu_op = ALU_SUB;
                is_slt = 1'b1;
                legal  = f7_ok;
            end
            default: begin
                alu_op = ALU_ADD;
                legal  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Main control FSM of the multicycle RV32I core. Sequences
//                fetch/decode/execute/memory/writeback and drives every
//                datapath enable and mux select.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,        // asynchronous, active low
    input  logic [6:0] Op,
    input  logic [2:0] F3,
    input  logic [6:0] F7,
    input  logic       Zero,
    input  logic       SignBit,
    output logic       PcEn,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IrWrite,
    output logic       RegWrite,
    output logic [2:0] Immsrc,
    output logic [1:0] AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] AluOp,
    output logic [1:0] ResultSrc,
    output logic [1:0] RegDataSel,
    output logic       Illegal
);

    state_t     state;
    state_t     state_next;

    logic       is_r_class;
    logic [2:0] dec_alu_op;
    logic       dec_is_slt;
    logic       dec_legal;

    logic       pc_en_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    // Op/F3/F7 come from the IR, which is stable from DECODE to the end of
    // the instruction, so the decoder output is valid in every later state.
    assign is_r_class = (Op == OP_R);

    alu_op_decoder u_alu_op_decoder (
        .is_r   (is_r_class),
        .f3     (F3),
        .f7     (F7),
        .alu_op (dec_alu_op),
        .is_slt (dec_is_slt),
        .legal  (dec_legal)
    );

    // State register, asynchronously cleared to FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: state_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW:
                        state_next = (F3 == F3_WORD) ? S_MEMADR : S_ILLEGAL;
                    OP_R:    state_next = dec_legal ? S_EXECR : S_ILLEGAL;
                    OP_I:    state_next = dec_legal ? S_EXECI : S_ILLEGAL;
                    OP_BR:   state_next = branch_f3_ok(F3) ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:  state_next = S_LINK;
                    OP_JALR: state_next = (F3 == F3_JALR) ? S_LINK : S_ILLEGAL;
                    OP_LUI:  state_next = S_LUI;
                    default: state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_LINK:     state_next = S_JUMP;
            S_JUMP:     state_next = S_FETCH;
            S_LUI:      state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_FETCH;
        endcase
    end

    // Per-state datapath controls; anything not assigned in a state is zero
    always_comb begin
        pc_en_raw     = 1'b0;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        Immsrc        = IMM_I;
        AluSrcA       = SRCA_PC;
        AluSrcB       = SRCB_RS2;
        AluOp         = ALU_ADD;
        ResultSrc     = RES_ALUOUTREG;
        RegDataSel    = RDS_RESULT;
        illegal_raw   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                AluSrcA      = SRCA_PC;
                AluSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALUOUT;
                pc_en_raw    = 1'b1;
            end
            S_DECODE: begin
                // Speculative branch target into AluOutReg
                AluSrcA = SRCA_OLDPC;
                AluSrcB = SRCB_IMM;
                Immsrc  = IMM_B;
            end
            S_MEMADR: begin
                AluSrcA = SRCA_RS1;
                AluSrcB = SRCB_IMM;
                Immsrc  = (Op == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUTREG;
            end
            S_MEMWB: begin
                ResultSrc     = RES_MDR;
                RegDataSel    = RDS_RESULT;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                ResultSrc     = RES_ALUOUTREG;
                mem_write_raw = 1'b1;
            end
            S_EXECR: begin
                AluSrcA = SRCA_RS1;
                AluSrcB = SRCB_RS2;
                AluOp   = dec_alu_op;
            end
            S_EXECI: begin
                AluSrcA = SRCA_RS1;
                AluSrcB = SRCB_IMM;
                Immsrc  = IMM_I;
                AluOp   = dec_alu_op;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                RegDataSel    = dec_is_slt ? RDS_SIGNBIT : RDS_ALUOUTREG;
            end
            S_BRANCH: begin
                AluSrcA   = SRCA_RS1;
                AluSrcB   = SRCB_RS2;
                AluOp     = ALU_SUB;
                ResultSrc = RES_ALUOUTREG;
                pc_en_raw = branch_taken(F3, Zero, SignBit);
            end
            S_LINK: begin
                // PC already holds old PC + 4; park it in AluOutReg for rd
                AluSrcA = SRCA_PC;
                AluSrcB = SRCB_ZERO;
            end
            S_JUMP: begin
                if (Op == OP_JAL) begin
                    AluSrcA = SRCA_OLDPC;
                    Immsrc  = IMM_J;
                end else begin
                    AluSrcA = SRCA_RS1;
                    Immsrc  = IMM_I;
                end
                AluSrcB       = SRCB_IMM;
                ResultSrc     = RES_ALUOUT;
                pc_en_raw     = 1'b1;
                reg_write_raw = 1'b1;
                RegDataSel    = RDS_ALUOUTREG;
            end
            S_LUI: begin
                Immsrc        = IMM_U;
                RegDataSel    = RDS_IMM;
                reg_write_raw = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_raw = 1'b1;
            end
            default: begin
                illegal_raw = 1'b0;
            end
        endcase
    end

    // Enables are forced low the instant reset asserts, not at the next edge
    always_comb begin
        PcEn     = pc_en_raw     & rst;
        MemWrite = mem_write_raw & rst;
        IrWrite  = ir_write_raw  & rst;
        RegWrite = reg_write_raw & rst;
        Illegal  = illegal_raw   & rst;
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. A per-
//                instruction reference model expands each instruction into
//                its expected cycle-by-cycle control vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_BR   = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_JALR = 7'b1100111;
    localparam logic [6:0] T_LUI  = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] F3;
    logic [6:0] F7;
    logic       Zero;
    logic       SignBit;
    logic       PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, Illegal;
    logic [2:0] Immsrc, AluOp;
    logic [1:0] AluSrcA, AluSrcB, ResultSrc, RegDataSel;

    int total = 0;
    int bad   = 0;

    logic [19:0] exp_q[$];
    logic [19:0] obs;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .F3         (F3),
        .F7         (F7),
        .Zero       (Zero),
        .SignBit    (SignBit),
        .PcEn       (PcEn),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IrWrite    (IrWrite),
        .RegWrite   (RegWrite),
        .Immsrc     (Immsrc),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .AluOp      (AluOp),
        .ResultSrc  (ResultSrc),
        .RegDataSel (RegDataSel),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    // Layout: PcEn AdrSrc MemWrite IrWrite RegWrite Immsrc A B AluOp ResultSrc RegDataSel Illegal
    assign obs = {PcEn, AdrSrc, MemWrite, IrWrite, RegWrite, Immsrc, AluSrcA, AluSrcB,
                  AluOp, ResultSrc, RegDataSel, Illegal};

    function automatic logic [19:0] pk(input logic pc, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [2:0] imm,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic [1:0] rs,
                                       input logic [1:0] rds, input logic ill);
        return {pc, adr, mw, irw, rw, imm, a, b, alu, rs, rds, ill};
    endfunction

    function automatic logic [19:0] v_fetch();
        return pk(1, 0, 0, 1, 0, 3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0);
    endfunction

    function automatic logic [19:0] v_reset();
        return pk(0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0);
    endfunction

    // Reference ALU operation for R (is_r=1) and I arithmetic
    function automatic logic [2:0] model_alu(input logic is_r, input logic [2:0] f3,
                                             input logic [6:0] f7);
        case (f3)
            3'b000:  return (is_r && f7 == 7'h20) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit model_legal(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7);
        bit alu_f3;
        alu_f3 = (f3 == 0) || (f3 == 7) || (f3 == 6) || (f3 == 4) || (f3 == 2);
        case (op)
            T_R:          return (f7 == 7'h00 && alu_f3) || (f7 == 7'h20 && f3 == 0);
            T_I:          return alu_f3;
            T_LW, T_SW:   return f3 == 3'b010;
            T_BR:         return (f3 == 0) || (f3 == 1) || (f3 == 4) || (f3 == 5);
            T_JAL, T_LUI: return 1'b1;
            T_JALR:       return f3 == 3'b000;
            default:      return 1'b0;
        endcase
    endfunction

    // Expand one instruction into its expected per-cycle control vectors
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic s, output bit legal);
        logic taken;
        exp_q.delete();
        legal = model_legal(op, f3, f7);
        exp_q.push_back(v_fetch());
        exp_q.push_back(pk(0, 0, 0, 0, 0, 3'b010, 2'b01, 2'b01, 3'b000, 2'b00, 2'b00, 0));
        if (!legal) begin
            repeat (20) exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            case (op)
                T_R, T_I: begin
                    exp_q.push_back(pk(0, 0, 0, 0, 0, 3'b000, 2'b10, (op == T_R) ? 2'b00 : 2'b01,
                                       model_alu(op == T_R, f3, f7), 2'b00, 2'b00, 0));
                    exp_q.push_back(pk(0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 3'b000, 2'b00,
                                       (f3 == 3'b010) ? 2'b11 : 2'b01, 0));
                end
                T_LW: begin
                    exp_q.push_back(pk(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0));
                    exp_q.push_back(pk(0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
                    exp_q.push_back(pk(0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0));
                end
                T_SW: begin
                    exp_q.push_back(pk(0, 0, 0, 0, 0, 3'b001, 2'b10, 2'b01, 0, 2'b00, 2'b00, 0));
                    exp_q.push_back(pk(0, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0));
                end
                T_BR: begin
                    if (f3 == 3'b000)      taken = z;
                    else if (f3 == 3'b001) taken = !z;
                    else if (f3 == 3'b100) taken = s;
                    else                   taken = !s;
                    exp_q.push_back(pk(taken, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 3'b001,
                                       2'b00, 2'b00, 0));
                end
                T_JAL, T_JALR: begin
                    exp_q.push_back(pk(0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b11, 0, 2'b00, 2'b00, 0));
                    exp_q.push_back(pk(1, 0, 0, 0, 1, (op == T_JAL) ? 3'b011 : 3'b000,
                                       (op == T_JAL) ? 2'b01 : 2'b10, 2'b01, 3'b000,
                                       2'b10, 2'b01, 0));
                end
                default: begin // lui
                    exp_q.push_back(pk(0, 0, 0, 0, 1, 3'b100, 2'b00, 2'b00, 0, 2'b00, 2'b10, 0));
                end
            endcase
        end
    endtask

    // Assert reset away from an edge, check the reset outputs, release on a negedge
    task automatic do_reset();
        rst = 1'b0;
        #1;
        total++;
        if (obs !== v_reset()) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, v_reset());
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Entered during a FETCH cycle before its rising edge; leaves in the next FETCH
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, input logic s);
        bit legal;
        Op = op; F3 = f3; F7 = f7; Zero = z; SignBit = s;
        build(op, f3, f7, z, s, legal);
        foreach (exp_q[k]) begin
            #1;
            total++;
            if (obs !== exp_q[k]) begin
                bad++;
                $display("FAIL %s cycle%0d got=%h exp=%h (op=%b f3=%b f7=%b z=%b s=%b)",
                         name, k, obs, exp_q[k], op, f3, f7, z, s);
            end
            @(posedge clk);
            #1;
        end
        if (!legal) do_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0; Op = '0; F3 = '0; F7 = '0; Zero = 1'b0; SignBit = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();
        // sw up to MEMWRITE, then pull reset mid-write
        Op = T_SW; F3 = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (MemWrite !== 1'b1) begin
            bad++;
            $display("FAIL memwrite_before_reset got=%b exp=1", MemWrite);
        end
        rst = 1'b0;
        #1;
        total++;
        if (obs !== v_reset()) begin
            bad++;
            $display("FAIL memwrite_drop got=%h exp=%h", obs, v_reset());
        end
        @(posedge clk);
        #1;
        total++;
        if (obs !== v_reset()) begin
            bad++;
            $display("FAIL held_in_reset got=%h exp=%h", obs, v_reset());
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (obs !== v_fetch()) begin
            bad++;
            $display("FAIL first_fetch got=%h exp=%h", obs, v_fetch());
        end
    endtask

    task automatic test_alu();
        run_instr("add", T_R, 3'b000, 7'h00, 0, 0);
        run_instr("sub", T_R, 3'b000, 7'h20, 0, 0);
        run_instr("slt", T_R, 3'b010, 7'h00, 0, 1);
        run_instr("slti", T_I, 3'b010, 7'h55, 0, 0);
        run_instr("addi_f7", T_I, 3'b000, 7'h20, 0, 0);
    endtask

    task automatic test_mem();
        run_instr("lw", T_LW, 3'b010, 7'h00, 0, 0);
        run_instr("sw", T_SW, 3'b010, 7'h00, 0, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", T_BR, 3'b000, 7'h00, 1, 0);
        run_instr("beq_not", T_BR, 3'b000, 7'h00, 0, 0);
        run_instr("bge_neg", T_BR, 3'b101, 7'h00, 0, 1);
        run_instr("blt_neg", T_BR, 3'b100, 7'h00, 0, 1);
        run_instr("bne_ne", T_BR, 3'b001, 7'h00, 0, 0);
    endtask

    task automatic test_jump();
        run_instr("jal", T_JAL, 3'b101, 7'h11, 0, 0);
        run_instr("jalr", T_JALR, 3'b000, 7'h00, 0, 0);
        run_instr("lui", T_LUI, 3'b011, 7'h7f, 0, 0);
    endtask

    task automatic test_illegal();
        run_instr("ill_system", 7'b1110011, 3'b000, 7'h00, 0, 0);
        run_instr("ill_r_f3_001", T_R, 3'b001, 7'h00, 0, 0);
        run_instr("after_illegal", T_R, 3'b100, 7'h00, 0, 0);
    endtask

    task automatic test_random();
        logic [2:0] alu_f3 [5];
        logic [2:0] br_f3  [4];
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        alu_f3 = '{3'd0, 3'd7, 3'd6, 3'd4, 3'd2};
        br_f3  = '{3'd0, 3'd1, 3'd4, 3'd5};
        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            case ($urandom_range(0, 9))
                0: begin
                    op = T_R;
                    f3 = alu_f3[$urandom_range(0, 4)];
                    f7 = (f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                end
                1: begin op = T_I; f3 = alu_f3[$urandom_range(0, 4)]; end
                2: begin op = T_LW; f3 = 3'b010; end
                3: begin op = T_SW; f3 = 3'b010; end
                4: begin op = T_BR; f3 = br_f3[$urandom_range(0, 3)]; end
                5: op = T_JAL;
                6: begin op = T_JALR; f3 = 3'b000; end
                7: op = T_LUI;
                8: op = 7'($urandom);
                default: begin
                    op = T_R;
                    if ($urandom_range(0, 1) == 1) f7 = 7'h00;
                end
            endcase
            run_instr("random", op, f3, f7, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_jump();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
